// File: rtl/div_param.sv
// Iterative restoring divider with optional two's-complement mode.
// One quotient bit per CALC cycle; a zero divisor short-circuits straight
// to DONE with hi = dividend and lo = all ones.
module div_param #(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             divControl,
  input  logic             isSigned,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             divStop,
  output logic             divZero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem, quot, dvsr;
  logic             neg_q, neg_r;
  logic             sgn_mode, a_neg, b_neg, b_zero;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             unused_bit;

  // Two's-complement magnitude; the most-negative value maps to 2^(WIDTH-1),
  // which is still representable as an unsigned WIDTH-bit magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  // Re-apply a sign to an unsigned magnitude (wraps for the overflow case).
  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                  input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  assign sgn_mode = SIGNED_EN & isSigned;
  assign a_neg    = sgn_mode & a[WIDTH-1];
  assign b_neg    = sgn_mode & b[WIDTH-1];
  assign b_zero   = (b == '0);

  // Shift {rem, quot} left by one and trial-subtract the divisor magnitude.
  // The top bit of trial is the borrow: set means restore.
  assign shifted    = {rem, quot[WIDTH-1]};
  assign trial      = {1'b0, shifted} - {2'b00, dvsr};
  // A successful subtraction always leaves a value below dvsr < 2^WIDTH.
  assign unused_bit = trial[WIDTH];

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and status outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    divStop   = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (divControl) state_nxt = b_zero ? DONE : CALC;
      end
      CALC: if (count <= CW'(1)) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: begin
        divStop   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, restoring iteration and result write-back.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count   <= '0;
      rem     <= '0;
      quot    <= '0;
      dvsr    <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      divZero <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (divControl) begin
            if (b_zero) begin
              divZero <= 1'b1;
              hi      <= a;
              lo      <= '1;
            end else begin
              divZero <= 1'b0;
              rem     <= '0;
              quot    <= magnitude(a, a_neg);
              dvsr    <= magnitude(b, b_neg);
              neg_q   <= a_neg ^ b_neg;
              neg_r   <= a_neg;
              count   <= CW'(WIDTH);
            end
          end
        end
        CALC: begin
          if (count != '0) count <= count - 1'b1;
          quot <= {quot[WIDTH-2:0], ~trial[WIDTH+1]};
          rem  <= trial[WIDTH+1] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        end
        FIX: begin
          lo <= apply_sign(quot, neg_q);
          hi <= apply_sign(rem, neg_r);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_param.sv
// Bench for div_param: a 32-bit and an 8-bit instance share clock and reset.
// Expected results come from native integer division and are queued at
// start time, then popped when divStop is seen.
module tb_div_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        dc32, sg32, busy32, stop32, dz32;
  logic [31:0] a32, b32, hi32, lo32;
  logic        dc8, sg8, busy8, stop8, dz8;
  logic [7:0]  a8, b8, hi8, lo8;

  div_param #(.WIDTH(32), .SIGNED_EN(1'b1)) u32 (
    .clk(clk), .reset(reset), .divControl(dc32), .isSigned(sg32),
    .a(a32), .b(b32), .busy(busy32), .divStop(stop32), .divZero(dz32),
    .hi(hi32), .lo(lo32));

  div_param #(.WIDTH(8), .SIGNED_EN(1'b1)) u8 (
    .clk(clk), .reset(reset), .divControl(dc8), .isSigned(sg8),
    .a(a8), .b(b8), .busy(busy8), .divStop(stop8), .divZero(dz8),
    .hi(hi8), .lo(lo8));

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
  } exp_t;

  exp_t scb[$];
  int   tests = 0;
  int   fails = 0;

  function automatic exp_t model(input bit w8, input logic sgn,
                                 input logic [31:0] a, input logic [31:0] b);
    longint      sa, sbv, q, r;
    exp_t        e;
    logic [31:0] mask;
    logic [31:0] am, bm;
    mask = w8 ? 32'h0000_00FF : 32'hFFFF_FFFF;
    am = a & mask;
    bm = b & mask;
    if (bm == 0) begin
      e.lo = mask; e.hi = am; e.dz = 1'b1;
      return e;
    end
    if (sgn) begin
      sa  = w8 ? longint'($signed(am[7:0])) : longint'($signed(am));
      sbv = w8 ? longint'($signed(bm[7:0])) : longint'($signed(bm));
    end else begin
      sa  = longint'(am);
      sbv = longint'(bm);
    end
    q = sa / sbv;
    r = sa % sbv;
    e.lo = 32'(q) & mask;
    e.hi = 32'(r) & mask;
    e.dz = 1'b0;
    return e;
  endfunction

  function automatic logic stop_of(input bit w8);
    return w8 ? stop8 : stop32;
  endfunction
  function automatic logic busy_of(input bit w8);
    return w8 ? busy8 : busy32;
  endfunction
  function automatic logic dz_of(input bit w8);
    return w8 ? dz8 : dz32;
  endfunction
  function automatic logic [31:0] lo_of(input bit w8);
    return w8 ? {24'd0, lo8} : lo32;
  endfunction
  function automatic logic [31:0] hi_of(input bit w8);
    return w8 ? {24'd0, hi8} : hi32;
  endfunction

  task automatic drive(input bit w8, input logic go, input logic sgn,
                       input logic [31:0] a, input logic [31:0] b);
    if (w8) begin
      dc8 = go; sg8 = sgn; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      dc32 = go; sg32 = sgn; a32 = a; b32 = b;
    end
  endtask

  // Presents a start for exactly one edge (edge 0); returns 1 ns after it.
  task automatic start_op(input bit w8, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input bit push);
    @(posedge clk); #1;
    drive(w8, 1'b1, sgn, a, b);
    if (push) scb.push_back(model(w8, sgn, a, b));
    @(posedge clk); #1;
    drive(w8, 1'b0, sgn, a, b);
  endtask

  // Counts falling edges after edge 0 until divStop; n = 1 means the cycle after edge 0.
  task automatic wait_stop(input bit w8, output int n, output bit seen);
    n = 0; seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      if (stop_of(w8)) seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    tests++;
    if ({busy32, stop32, dz32, hi32, lo32} !== 67'd0) begin
      fails++;
      $display("FAIL reset32 got busy=%b stop=%b dz=%b hi=%h lo=%h, required all zero",
               busy32, stop32, dz32, hi32, lo32);
    end
    tests++;
    if ({busy8, stop8, dz8, hi8, lo8} !== 19'd0) begin
      fails++;
      $display("FAIL reset8 got busy=%b stop=%b dz=%b hi=%h lo=%h, required all zero",
               busy8, stop8, dz8, hi8, lo8);
    end
    reset = 1'b1;
  endtask

  task automatic test_unsigned;
    int n; bit seen; exp_t e;
    logic [31:0] ta [4];
    logic [31:0] tb [4];
    ta[0] = 32'd100;        tb[0] = 32'd7;
    ta[1] = 32'hFFFF_FFFF;  tb[1] = 32'd1;
    ta[2] = 32'd5;          tb[2] = 32'hFFFF_FFFF;
    ta[3] = $urandom;       tb[3] = $urandom_range(1, 100000);
    for (int i = 0; i < 4; i++) begin
      start_op(1'b0, 1'b0, ta[i], tb[i], 1'b1);
      wait_stop(1'b0, n, seen);
      e = scb.pop_front();
      tests++;
      if (!seen || n != 34) begin
        fails++;
        $display("FAIL unsigned_latency[%0d] got seen=%b cycles=%0d, required 34", i, seen, n);
      end
      tests++;
      if ({lo32, hi32, dz32} !== {e.lo, e.hi, e.dz}) begin
        fails++;
        $display("FAIL unsigned_result[%0d] got lo=%h hi=%h dz=%b, required lo=%h hi=%h dz=%b",
                 i, lo32, hi32, dz32, e.lo, e.hi, e.dz);
      end
      @(negedge clk);
      tests++;
      if ({stop32, busy32} !== 2'b00) begin
        fails++;
        $display("FAIL unsigned_pulse[%0d] got stop=%b busy=%b one cycle later, required 0 0",
                 i, stop32, busy32);
      end
    end
  endtask

  task automatic test_signed;
    int n; bit seen; exp_t e;
    logic [31:0] ta [5];
    logic [31:0] tb [5];
    logic        ts [5];
    ta[0] = -32'sd20;  tb[0] = 32'd3;      ts[0] = 1'b1;
    ta[1] = 32'd20;    tb[1] = -32'sd3;    ts[1] = 1'b1;
    ta[2] = -32'sd20;  tb[2] = -32'sd3;    ts[2] = 1'b1;
    ta[3] = -32'sd20;  tb[3] = 32'd3;      ts[3] = 1'b0;
    ta[4] = $urandom;  tb[4] = $urandom | 32'h0000_0100; ts[4] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      start_op(1'b0, ts[i], ta[i], tb[i], 1'b1);
      wait_stop(1'b0, n, seen);
      e = scb.pop_front();
      tests++;
      if (!seen || {lo32, hi32, dz32} !== {e.lo, e.hi, e.dz}) begin
        fails++;
        $display("FAIL signed_result[%0d] got seen=%b lo=%h hi=%h dz=%b, required lo=%h hi=%h dz=%b",
                 i, seen, lo32, hi32, dz32, e.lo, e.hi, e.dz);
      end
    end
  endtask

  task automatic test_div_zero;
    int n; bit seen; exp_t e;
    start_op(1'b0, 1'b0, 32'h1234_5678, 32'd0, 1'b1);
    wait_stop(1'b0, n, seen);
    e = scb.pop_front();
    tests++;
    if (!seen || n != 1) begin
      fails++;
      $display("FAIL divzero_latency got seen=%b cycles=%0d, required 1", seen, n);
    end
    tests++;
    if ({lo32, hi32, dz32} !== {e.lo, e.hi, e.dz}) begin
      fails++;
      $display("FAIL divzero_result got lo=%h hi=%h dz=%b, required lo=%h hi=%h dz=%b",
               lo32, hi32, dz32, e.lo, e.hi, e.dz);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (dz32 !== 1'b1) begin
      fails++;
      $display("FAIL divzero_hold got dz=%b, required 1", dz32);
    end
    start_op(1'b0, 1'b0, 32'd77, 32'd1, 1'b1);
    tests++;
    if (dz32 !== 1'b0) begin
      fails++;
      $display("FAIL divzero_clear got dz=%b right after accept, required 0", dz32);
    end
    wait_stop(1'b0, n, seen);
    e = scb.pop_front();
    tests++;
    if (!seen || {lo32, hi32, dz32} !== {e.lo, e.hi, e.dz}) begin
      fails++;
      $display("FAIL divone_result got seen=%b lo=%h hi=%h dz=%b, required lo=%h hi=%h dz=%b",
               seen, lo32, hi32, dz32, e.lo, e.hi, e.dz);
    end
  endtask

  task automatic test_overflow;
    int n; bit seen;
    start_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_stop(1'b0, n, seen);
    tests++;
    if (!seen || {lo32, hi32, dz32} !== {32'h8000_0000, 32'h0, 1'b0}) begin
      fails++;
      $display("FAIL overflow32 got seen=%b lo=%h hi=%h dz=%b, required lo=80000000 hi=0 dz=0",
               seen, lo32, hi32, dz32);
    end
    start_op(1'b1, 1'b1, 32'h80, 32'hFF, 1'b0);
    wait_stop(1'b1, n, seen);
    tests++;
    if (!seen || n != 10 || {lo8, hi8, dz8} !== {8'h80, 8'h00, 1'b0}) begin
      fails++;
      $display("FAIL overflow8 got seen=%b cycles=%0d lo=%h hi=%h dz=%b, required 10 cycles lo=80 hi=0 dz=0",
               seen, n, lo8, hi8, dz8);
    end
  endtask

  task automatic test_reset_mid;
    int n; bit seen; exp_t e;
    start_op(1'b0, 1'b0, 32'd100, 32'd7, 1'b0);
    repeat (10) @(negedge clk);
    reset = 1'b0;
    #1;
    tests++;
    if ({busy32, stop32, dz32, hi32, lo32} !== 67'd0) begin
      fails++;
      $display("FAIL midreset_clear got busy=%b stop=%b dz=%b hi=%h lo=%h, required all zero",
               busy32, stop32, dz32, hi32, lo32);
    end
    drive(1'b0, 1'b1, 1'b0, 32'd9, 32'd3);
    scb.push_back(model(1'b0, 1'b0, 32'd9, 32'd3));
    @(negedge clk);
    tests++;
    if ({busy32, stop32} !== 2'b00) begin
      fails++;
      $display("FAIL midreset_hold got busy=%b stop=%b while in reset, required 0 0", busy32, stop32);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'd9, 32'd3);
    tests++;
    if (busy32 !== 1'b1) begin
      fails++;
      $display("FAIL midreset_accept got busy=%b after first edge out of reset, required 1", busy32);
    end
    wait_stop(1'b0, n, seen);
    e = scb.pop_front();
    tests++;
    if (!seen || n != 34 || {lo32, hi32, dz32} !== {e.lo, e.hi, e.dz}) begin
      fails++;
      $display("FAIL midreset_restart got seen=%b cycles=%0d lo=%h hi=%h, required 34 cycles lo=%h hi=%h",
               seen, n, lo32, hi32, e.lo, e.hi);
    end
  endtask

  function automatic logic [31:0] opa(input bit w8, input int c);
    if (w8) return (c == 0) ? 32'd255 : 32'((c * 29 + 3) & 255);
    return 32'(1000 + c * 37);
  endfunction
  function automatic logic [31:0] opb(input bit w8, input int c);
    if (w8) return (c == 0) ? 32'd16 : 32'(1 + c % 9);
    return 32'(3 + c % 5);
  endfunction

  task automatic test_back_to_back(input bit w8);
    int p, prev, got; exp_t e;
    p = w8 ? 11 : 35;
    prev = -1; got = 0;
    @(posedge clk); #1;
    drive(w8, 1'b1, 1'b0, opa(w8, 0), opb(w8, 0));
    scb.push_back(model(w8, 1'b0, opa(w8, 0), opb(w8, 0)));
    for (int i = 0; i < 3 * p - 1; i++) begin
      @(posedge clk); #1;
      drive(w8, 1'b1, 1'b0, opa(w8, i + 1), opb(w8, i + 1));
      if ((i + 1) % p == 0) scb.push_back(model(w8, 1'b0, opa(w8, i + 1), opb(w8, i + 1)));
      @(negedge clk);
      if (stop_of(w8)) begin
        e = scb.pop_front();
        tests++;
        if ({lo_of(w8), hi_of(w8), dz_of(w8)} !== {e.lo, e.hi, e.dz}) begin
          fails++;
          $display("FAIL b2b_result w8=%0d #%0d got lo=%h hi=%h dz=%b, required lo=%h hi=%h dz=%b",
                   w8, got, lo_of(w8), hi_of(w8), dz_of(w8), e.lo, e.hi, e.dz);
        end
        if (prev >= 0) begin
          tests++;
          if (i - prev != p) begin
            fails++;
            $display("FAIL b2b_spacing w8=%0d got %0d cycles, required %0d", w8, i - prev, p);
          end
        end
        prev = i;
        got++;
      end
    end
    @(posedge clk); #1;
    drive(w8, 1'b0, 1'b0, 32'd0, 32'd1);
    @(negedge clk);
    tests++;
    if (got != 3 || busy_of(w8) !== 1'b0 || scb.size() != 0) begin
      fails++;
      $display("FAIL b2b_count w8=%0d got results=%0d busy=%b pending=%0d, required 3 0 0",
               w8, got, busy_of(w8), scb.size());
    end
    scb.delete();
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_reset_mid();
    test_back_to_back(1'b0);
    test_back_to_back(1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

endmodule
